mem_wb_stage_param: RTL and testbench
=====================================

# mem_wb_stage_param

Parametrised memory stage for the in-order pipeline. It holds the data memory, performs loads and stores with byte or full-word access and sign or zero extension, and applies a configurable read latency that stalls upstream stages with a small FSM. It registers results into the MEM/WB pipeline register. It sits between the EX/MEM register and the writeback mux, and generalises the 8-bit single-cycle MEM stage.

## Interface
Parameters:
- DATA_W, default 8: datapath width. Must be a multiple of 8 and at least 8.
- ADDR_W, default 8: word-address width. Memory depth is 2**ADDR_W words of DATA_W bits.
- REG_W, default 3: register index width.
- READ_LAT, default 1: load latency in cycles, range 1 to 4.

Ports (clock and reset: one clock; reset is synchronous and active-high):
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- valid_MEM  in  1  the MEM slot holds a real instruction.
- MemRead_MEM  in  1  load.
- MemWrite_MEM  in  1  store.
- ByteOp_MEM  in  1  1 = byte access on the low 8 bits; 0 = full word.
- Unsigned_MEM  in  1  byte load zero-extends when 1 and sign-extends when 0.
- ResultSrc_MEM  in  1  passed to WB (1 = memory data).
- RegWrite_MEM  in  1  passed to WB.
- rd_MEM  in  REG_W  destination register.
- alu_result_MEM  in  DATA_W  address (low ADDR_W bits) and pass-through result.
- write_data_MEM  in  DATA_W  store data.
- stall_MEM  out  1  combinational; high while a load is waiting for data.
- mem_data_WB  out  DATA_W  registered, extended load data.
- alu_result_WB  out  DATA_W  registered.
- ResultSrc_WB, RegWrite_WB, valid_WB  out  1 each  registered.
- rd_WB  out  REG_W  registered.

## Operation
- Address is alu_result_MEM[ADDR_W-1:0]. Upper bits are ignored, so addresses wrap modulo depth.
- Store (valid_MEM & MemWrite_MEM):
  - Single cycle; memory is updated at the end of the cycle; no stall.
  - Full-word store writes all DATA_W bits.
  - Byte store writes bits [7:0] only and preserves the upper bits. When DATA_W = 8, ByteOp_MEM has no effect.
- MemRead and MemWrite asserted together is illegal. The block treats it as a store: no stall, and WB data is the alu_result path.
- Load (valid_MEM & MemRead_MEM):
  - Full word: the data is passed through unchanged.
  - Byte: bits [7:0] are extended to DATA_W (sign-extended or zero-extended per Unsigned_MEM).
- FSM states: IDLE, WAIT.
  - IDLE → WAIT when a load is valid and READ_LAT > 1. A wait counter is loaded with READ_LAT-2.
  - WAIT decrements the counter each cycle and returns to IDLE on the cycle the counter is 0.
  - stall_MEM = 1 in the IDLE acceptance cycle (when READ_LAT > 1) and in every WAIT cycle except the last.
- While stall_MEM = 1, upstream holds all *_MEM inputs stable, and the WB register captures a bubble: valid_WB = 0, RegWrite_WB = 0, other fields unchanged.
- Non-load instructions, and bubbles (valid_MEM = 0), never stall.
- For a bubble, WB captures valid_WB = 0 and RegWrite_WB = 0.
- Memory contents are not cleared by reset. Software or the bench must write a location before reading it.

## Timing
- Reset values: mem_data_WB = 0, alu_result_WB = 0, ResultSrc_WB = 0, RegWrite_WB = 0, valid_WB = 0, rd_WB = 0. FSM = IDLE, counter = 0, stall_MEM = 0.
- Load accepted in cycle T:
  - stall_MEM is high in cycles T .. T+READ_LAT-2.
  - WB outputs present the load in cycle T+READ_LAT, after the edge that ends cycle T+READ_LAT-1.
  - With READ_LAT = 1 there is no stall, and WB is valid in cycle T+1.
- Non-load instructions: the WB outputs are valid exactly one cycle after the instruction appears on the MEM inputs.
- Store followed by a load to the same address in the next cycle returns the new data.
- Reset asserted mid-WAIT: on that edge, FSM → IDLE, stall_MEM drops low in the following cycle, all WB outputs go to their reset values, and the pending load is discarded.
- Back-to-back loads: a second load is accepted on the cycle after the first one releases stall. Throughput is one load per READ_LAT cycles.

## Test plan
- READ_LAT = 1, DATA_W = 8:
  - Stimulus: store 0xA5 to addr 3, then load addr 3 with RegWrite_MEM = 1 and rd_MEM = 5.
  - Required: next cycle mem_data_WB = 0xA5, rd_WB = 5, RegWrite_WB = 1, valid_WB = 1, stall_MEM never high.
- DATA_W = 16, word 0x12F0 at addr 7:
  - Byte load, signed: mem_data_WB = 0xFFF0.
  - Byte load, unsigned: mem_data_WB = 0x00F0.
  - Byte store 0x3C, then word load: mem_data_WB = 0x123C.
- READ_LAT = 3, load in cycle T:
  - stall_MEM = 1 in T and T+1 and 0 in T+2.
  - valid_WB = 0 in T+1 and T+2.
  - valid_WB = 1 with the data in T+3.
- READ_LAT = 4: assert reset during the second WAIT cycle. Required: all WB outputs are 0 after that edge, stall_MEM = 0 the following cycle, and no stale load appears later.
- ADDR_W = 4: store 0x55 with alu_result_MEM = 0x13, then load address 0x03. Required: mem_data_WB = 0x55 (address wrap).
- Bubble and conflict cases:
  - valid_MEM = 0 with MemRead_MEM = 1: no stall, and valid_WB = 0 and RegWrite_WB = 0 next cycle.
  - MemRead and MemWrite both asserted: the store is performed and no stall occurs.

Source files
------------

// File: rtl/mem_wb_stage_param.sv
// MEM stage with data memory, byte/word access, configurable load latency
// and the MEM/WB pipeline register.
module mem_wb_stage_param #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int REG_W    = 3,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_MEM,
    input  logic              MemRead_MEM,
    input  logic              MemWrite_MEM,
    input  logic              ByteOp_MEM,
    input  logic              Unsigned_MEM,
    input  logic              ResultSrc_MEM,
    input  logic              RegWrite_MEM,
    input  logic [REG_W-1:0]  rd_MEM,
    input  logic [DATA_W-1:0] alu_result_MEM,
    input  logic [DATA_W-1:0] write_data_MEM,
    output logic              stall_MEM,
    output logic [DATA_W-1:0] mem_data_WB,
    output logic [DATA_W-1:0] alu_result_WB,
    output logic              ResultSrc_WB,
    output logic              RegWrite_WB,
    output logic              valid_WB,
    output logic [REG_W-1:0]  rd_WB
);
    typedef enum logic {IDLE, WAIT} state_t;

    localparam int              DEPTH     = 1 << ADDR_W;
    localparam logic [1:0]      CNT_INIT  = (READ_LAT > 1) ? 2'(READ_LAT - 2) : 2'd0;
    localparam logic [DATA_W-1:0] BYTE_MASK = DATA_W'(8'hFF);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] addr;
    logic              is_store, is_load;
    logic [DATA_W-1:0] rdata, wdata, load_data;
    state_t            state, state_nxt;
    logic [1:0]        cnt, cnt_nxt;

    assign addr     = alu_result_MEM[ADDR_W-1:0];
    assign is_store = valid_MEM & MemWrite_MEM;
    // A simultaneous read+write request is handled as a plain store.
    assign is_load  = valid_MEM & MemRead_MEM & ~MemWrite_MEM;
    assign rdata    = mem[addr];

    // Byte store merges the low byte into the existing word.
    assign wdata = ByteOp_MEM ? ((rdata & ~BYTE_MASK) | (write_data_MEM & BYTE_MASK))
                              : write_data_MEM;

    always_comb begin
        load_data = rdata;
        if (ByteOp_MEM)
            load_data = Unsigned_MEM ? DATA_W'(rdata[7:0]) : DATA_W'($signed(rdata[7:0]));
    end

    always_ff @(posedge clk) begin
        if (is_store)
            mem[addr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 2'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall_MEM = 1'b0;
        case (state)
            IDLE: begin
                if (is_load && READ_LAT > 1) begin
                    state_nxt = WAIT;
                    cnt_nxt   = CNT_INIT;
                    stall_MEM = 1'b1;
                end
            end
            WAIT: begin
                // Last WAIT cycle releases the stall and lets WB capture the load.
                if (cnt == 2'd0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt   = cnt - 2'd1;
                    stall_MEM = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_data_WB   <= '0;
            alu_result_WB <= '0;
            ResultSrc_WB  <= 1'b0;
            RegWrite_WB   <= 1'b0;
            valid_WB      <= 1'b0;
            rd_WB         <= '0;
        end else if (stall_MEM) begin
            valid_WB    <= 1'b0;
            RegWrite_WB <= 1'b0;
        end else begin
            valid_WB      <= valid_MEM;
            RegWrite_WB   <= valid_MEM & RegWrite_MEM;
            ResultSrc_WB  <= ResultSrc_MEM;
            rd_WB         <= rd_MEM;
            alu_result_WB <= alu_result_MEM;
            if (is_load)
                mem_data_WB <= load_data;
        end
    end
endmodule

// File: tb/tb_mem_wb_stage_param.sv
// Directed bench: four configurations sharing one stimulus bus, a vector
// table for the 16-bit single-cycle case and hand sequences for latency/reset.
module tb_mem_wb_stage_param;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic        clk = 1'b0;
    logic        reset;
    logic        vm, mrd, mwr, byo, uns, rsm, rwm;
    logic [2:0]  rdi;
    logic [15:0] alu, wd;

    // i0: 8b, ADDR_W=4, LAT1   i1: 16b, LAT1   i2: 8b, LAT3   i3: 8b, LAT4
    logic        st0, st1, st2, st3;
    logic [7:0]  md0, md2, md3, aw0, aw2, aw3;
    logic [15:0] md1, aw1;
    logic        rs0, rs1, rs2, rs3, rw0, rw1, rw2, rw3, vw0, vw1, vw2, vw3;
    logic [2:0]  rdw0, rdw1, rdw2, rdw3;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mem_wb_stage_param #(.DATA_W(8), .ADDR_W(4), .REG_W(3), .READ_LAT(1)) i0 (
        .clk(clk), .reset(reset), .valid_MEM(vm), .MemRead_MEM(mrd), .MemWrite_MEM(mwr),
        .ByteOp_MEM(byo), .Unsigned_MEM(uns), .ResultSrc_MEM(rsm), .RegWrite_MEM(rwm),
        .rd_MEM(rdi), .alu_result_MEM(alu[7:0]), .write_data_MEM(wd[7:0]), .stall_MEM(st0),
        .mem_data_WB(md0), .alu_result_WB(aw0), .ResultSrc_WB(rs0), .RegWrite_WB(rw0),
        .valid_WB(vw0), .rd_WB(rdw0));

    mem_wb_stage_param #(.DATA_W(16), .ADDR_W(8), .REG_W(3), .READ_LAT(1)) i1 (
        .clk(clk), .reset(reset), .valid_MEM(vm), .MemRead_MEM(mrd), .MemWrite_MEM(mwr),
        .ByteOp_MEM(byo), .Unsigned_MEM(uns), .ResultSrc_MEM(rsm), .RegWrite_MEM(rwm),
        .rd_MEM(rdi), .alu_result_MEM(alu), .write_data_MEM(wd), .stall_MEM(st1),
        .mem_data_WB(md1), .alu_result_WB(aw1), .ResultSrc_WB(rs1), .RegWrite_WB(rw1),
        .valid_WB(vw1), .rd_WB(rdw1));

    mem_wb_stage_param #(.DATA_W(8), .ADDR_W(8), .REG_W(3), .READ_LAT(3)) i2 (
        .clk(clk), .reset(reset), .valid_MEM(vm), .MemRead_MEM(mrd), .MemWrite_MEM(mwr),
        .ByteOp_MEM(byo), .Unsigned_MEM(uns), .ResultSrc_MEM(rsm), .RegWrite_MEM(rwm),
        .rd_MEM(rdi), .alu_result_MEM(alu[7:0]), .write_data_MEM(wd[7:0]), .stall_MEM(st2),
        .mem_data_WB(md2), .alu_result_WB(aw2), .ResultSrc_WB(rs2), .RegWrite_WB(rw2),
        .valid_WB(vw2), .rd_WB(rdw2));

    mem_wb_stage_param #(.DATA_W(8), .ADDR_W(8), .REG_W(3), .READ_LAT(4)) i3 (
        .clk(clk), .reset(reset), .valid_MEM(vm), .MemRead_MEM(mrd), .MemWrite_MEM(mwr),
        .ByteOp_MEM(byo), .Unsigned_MEM(uns), .ResultSrc_MEM(rsm), .RegWrite_MEM(rwm),
        .rd_MEM(rdi), .alu_result_MEM(alu[7:0]), .write_data_MEM(wd[7:0]), .stall_MEM(st3),
        .mem_data_WB(md3), .alu_result_WB(aw3), .ResultSrc_WB(rs3), .RegWrite_WB(rw3),
        .valid_WB(vw3), .rd_WB(rdw3));

    typedef struct {
        logic v, rd, wr, by, un, rs, rw;
        logic [2:0]  ri;
        logic [15:0] a, w;
        logic ev, erw, cd;
        logic [15:0] ed;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        else
            passed++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic r, input logic w, input logic b,
                          input logic u, input logic s, input logic rw,
                          input logic [2:0] ri, input logic [15:0] a, input logic [15:0] d);
        vm = v; mrd = r; mwr = w; byo = b; uns = u; rsm = s; rwm = rw;
        rdi = ri; alu = a; wd = d;
        #1;
    endtask

    task automatic bubble();
        set_in(L, L, L, L, L, L, L, 3'd0, 16'h0, 16'h0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bubble();
        step();
        step();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b0;
        bubble();
        do_reset();

        chk("reset_i0", {md0, aw0, rs0, rw0, vw0, rdw0, st0}, 32'h0);
        chk("reset_i1", {md1, aw1}, 32'h0);
        chk("reset_i1_ctl", {rs1, rw1, vw1, rdw1, st1}, 32'h0);
        chk("reset_i2", {md2, aw2, rs2, rw2, vw2, rdw2, st2}, 32'h0);
        chk("reset_i3", {md3, aw3, rs3, rw3, vw3, rdw3, st3}, 32'h0);

        // 8-bit, single cycle: store then load same address
        set_in(H, L, H, L, L, L, L, 3'd0, 16'h0003, 16'h00A5);
        chk("lat1_store_stall", {31'd0, st0}, 32'd0);
        step();
        set_in(H, H, L, L, L, H, H, 3'd5, 16'h0003, 16'h0000);
        chk("lat1_load_stall", {31'd0, st0}, 32'd0);
        step();
        chk("lat1_load_data", {24'd0, md0}, 32'hA5);
        chk("lat1_load_ctl", {28'd0, vw0, rw0, rdw0}, {28'd0, 1'b1, 1'b1, 3'd5});
        // address wrap with ADDR_W = 4
        set_in(H, L, H, L, L, L, L, 3'd0, 16'h0013, 16'h0055);
        step();
        set_in(H, H, L, L, L, H, H, 3'd1, 16'h0003, 16'h0000);
        step();
        chk("addr_wrap_data", {24'd0, md0}, 32'h55);

        //          v  rd wr by un rs rw ri    a         w          ev erw cd ed
        tbl[0] = '{H, L, H, L, L, L, L, 3'd0, 16'h0007, 16'h12F0, H, L, L, 16'h0000};
        tbl[1] = '{H, H, L, H, L, H, H, 3'd2, 16'h0007, 16'h0000, H, H, H, 16'hFFF0};
        tbl[2] = '{H, H, L, H, H, H, H, 3'd3, 16'h0007, 16'h0000, H, H, H, 16'h00F0};
        tbl[3] = '{H, L, H, H, L, L, L, 3'd0, 16'h0007, 16'hAB3C, H, L, L, 16'h0000};
        tbl[4] = '{H, H, L, L, L, H, H, 3'd4, 16'h0007, 16'h0000, H, H, H, 16'h123C};
        tbl[5] = '{H, L, H, L, L, L, L, 3'd0, 16'h0107, 16'h0080, H, L, L, 16'h0000};
        tbl[6] = '{H, H, L, H, L, H, H, 3'd5, 16'h0307, 16'h0000, H, H, H, 16'hFF80};
        tbl[7] = '{L, H, L, L, L, H, H, 3'd6, 16'h0007, 16'h0000, L, L, L, 16'h0000};
        tbl[8] = '{H, H, H, L, L, L, H, 3'd7, 16'h0009, 16'h5555, H, H, L, 16'h0000};
        tbl[9] = '{H, H, L, L, L, H, H, 3'd1, 16'h0009, 16'h0000, H, H, H, 16'h5555};

        for (int i = 0; i < 10; i++) begin
            set_in(tbl[i].v, tbl[i].rd, tbl[i].wr, tbl[i].by, tbl[i].un, tbl[i].rs,
                   tbl[i].rw, tbl[i].ri, tbl[i].a, tbl[i].w);
            chk($sformatf("vec%0d_stall", i), {31'd0, st1}, 32'd0);
            step();
            chk($sformatf("vec%0d_vld_rw", i), {30'd0, vw1, rw1}, {30'd0, tbl[i].ev, tbl[i].erw});
            if (tbl[i].ev)
                chk($sformatf("vec%0d_rs_rd_alu", i), {12'd0, rs1, rdw1, aw1},
                    {12'd0, tbl[i].rs, tbl[i].ri, tbl[i].a});
            if (tbl[i].cd)
                chk($sformatf("vec%0d_data", i), {16'd0, md1}, {16'd0, tbl[i].ed});
        end

        // READ_LAT = 3 load timing
        do_reset();
        set_in(H, L, H, L, L, L, L, 3'd0, 16'h0005, 16'h0077);
        step();
        set_in(H, H, L, L, L, H, H, 3'd4, 16'h0005, 16'h0000);
        chk("lat3_stall_T", {31'd0, st2}, 32'd1);
        step();
        chk("lat3_T1", {30'd0, vw2, st2}, {30'd0, 1'b0, 1'b1});
        step();
        chk("lat3_T2", {30'd0, vw2, st2}, {30'd0, 1'b0, 1'b0});
        step();
        bubble();
        chk("lat3_T3", {19'd0, vw2, rw2, rdw2, md2}, {19'd0, 1'b1, 1'b1, 3'd4, 8'h77});

        // READ_LAT = 4, reset during second WAIT cycle
        do_reset();
        set_in(H, L, H, L, L, L, L, 3'd0, 16'h0006, 16'h0033);
        step();
        set_in(H, H, L, L, L, H, H, 3'd6, 16'h0006, 16'h0000);
        chk("lat4_stall_T", {31'd0, st3}, 32'd1);
        step();
        step();
        chk("lat4_stall_T2", {31'd0, st3}, 32'd1);
        reset = 1'b1;
        step();
        chk("lat4_reset_wb", {md3, aw3, rs3, rw3, vw3, rdw3}, 32'h0);
        reset = 1'b0;
        bubble();
        chk("lat4_stall_after", {31'd0, st3}, 32'd0);
        begin
            logic stale = 1'b0;
            for (int k = 0; k < 6; k++) begin
                step();
                if (vw3 || rw3 || st3) stale = 1'b1;
            end
            chk("lat4_no_stale", {31'd0, stale}, 32'd0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
